// File: rtl/key_event_decoder.sv
// Keypad event decoder: synchronises and debounces the scanner key code, then
// queues press/release events in a small FIFO drained through a valid/ready handshake.
module key_event_decoder #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4:0]                    keyout,
  output logic                          evt_valid,
  output logic [4:0]                    evt_data,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DEB,
    HELD,
    REL_DEB
  } state_t;

  logic [4:0]       s1;
  logic [4:0]       s2;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [3:0]       hc;
  logic [3:0]       hc_next;
  logic             key_match;
  logic             push;
  logic [4:0]       push_data;

  logic [4:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             pop;
  logic             do_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= keyout;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hc    <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      hc    <= hc_next;
    end
  end

  assign key_match = (s2 == {1'b1, hc});

  // Any code other than the held key (including a different key) counts as a release.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    hc_next    = hc;
    push       = 1'b0;
    push_data  = {1'b0, hc};
    case (state)
      IDLE: begin
        if (s2[4]) begin
          hc_next    = s2[3:0];
          cnt_next   = '0;
          state_next = PRESS_DEB;
        end
      end
      PRESS_DEB: begin
        if (!key_match) begin
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          push       = 1'b1;
          push_data  = {1'b1, hc};
          state_next = HELD;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!key_match) begin
          cnt_next   = '0;
          state_next = REL_DEB;
        end
      end
      REL_DEB: begin
        if (key_match) begin
          state_next = HELD;
        end else if (cnt == CNT_LAST) begin
          push       = 1'b1;
          push_data  = {1'b0, hc};
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign full     = (count == FULL_COUNT);
  assign pop      = evt_valid && evt_ready;
  assign do_write = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // A simultaneous pop frees the head slot, so a push into a full FIFO still lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_write && !pop) begin
        count <= count + 1'b1;
      end else if (!do_write && pop) begin
        count <= count - 1'b1;
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  assign evt_valid  = (count != '0);
  assign evt_data   = evt_valid ? mem[rd_ptr] : 5'h00;
  assign fifo_count = count;

endmodule
